// File: rtl/wavetable_voice_sched.sv
// Per-sample voice scanner for a shared single-port wavetable RAM. It steps each
// voice phase, sums one wavetable word per voice and fits host reloads between scans.
module wavetable_voice_sched #(
    parameter int NVOICE  = 4,
    parameter int PHASE_W = 24,
    localparam int MIX_W  = 16 + $clog2(NVOICE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sample_tick,
    input  logic [NVOICE-1:0]         voice_en,
    input  logic [NVOICE*PHASE_W-1:0] voice_inc,
    input  logic                      host_req,
    input  logic [8:0]                host_addr,
    input  logic [15:0]               host_wdata,
    output logic                      host_ack,
    output logic [8:0]                ram_addr,
    output logic [15:0]               ram_wdata,
    input  logic [15:0]               ram_rdata,
    output logic                      ce,
    output logic                      we,
    output logic                      re,
    output logic [MIX_W-1:0]          mix_out,
    output logic                      mix_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int VW = $clog2(NVOICE);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, HOSTWR} state_t;

    state_t             state;
    logic [VW-1:0]      v;
    logic [PHASE_W-1:0] phase [NVOICE];
    logic [MIX_W-1:0]   acc;
    logic               en_p1;
    logic [MIX_W-1:0]   sum_p1;

    function automatic logic [MIX_W-1:0] gated_sample(input logic en, input logic [15:0] s);
        return en ? MIX_W'(s) : '0;
    endfunction

    // Read data of the voice addressed last cycle joins the running sum here.
    assign sum_p1    = acc + gated_sample(en_p1, ram_rdata);
    assign ram_wdata = host_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            v         <= '0;
            acc       <= '0;
            en_p1     <= 1'b0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            busy      <= 1'b0;
            host_ack  <= 1'b0;
            overrun   <= 1'b0;
            ce        <= 1'b0;
            we        <= 1'b0;
            re        <= 1'b0;
            ram_addr  <= '0;
            for (int i = 0; i < NVOICE; i++) phase[i] <= '0;
        end else begin
            mix_valid <= 1'b0;
            if (sample_tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state    <= SCAN;
                        v        <= '0;
                        acc      <= '0;
                        en_p1    <= 1'b0;
                        busy     <= 1'b1;
                        ce       <= 1'b1;
                        re       <= 1'b1;
                        ram_addr <= phase[0][PHASE_W-1 -: 9];
                    end else if (host_req) begin
                        state    <= HOSTWR;
                        ram_addr <= host_addr;
                        ce       <= 1'b1;
                        we       <= 1'b1;
                        host_ack <= 1'b1;
                    end
                end
                SCAN: begin
                    // The read in flight used the pre-increment phase.
                    phase[v] <= voice_en[v] ? phase[v] + voice_inc[v*PHASE_W +: PHASE_W] : '0;
                    en_p1    <= voice_en[v];
                    acc      <= sum_p1;
                    if (v == VW'(NVOICE-1)) begin
                        state <= DRAIN;
                        ce    <= 1'b0;
                        re    <= 1'b0;
                    end else begin
                        v        <= v + 1'b1;
                        ram_addr <= phase[v + 1'b1][PHASE_W-1 -: 9];
                    end
                end
                DRAIN: begin
                    mix_out   <= sum_p1;
                    mix_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                HOSTWR: begin
                    state    <= IDLE;
                    ce       <= 1'b0;
                    we       <= 1'b0;
                    host_ack <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wavetable_voice_sched.sv
// Bench for wavetable_voice_sched: a timeline model of the scheduler plus a RAM
// model, checked every cycle, with directed scenarios pinned to literal values.
module tb_wavetable_voice_sched;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_tick;
    logic [3:0]  voice_en;
    logic [95:0] voice_inc;
    logic        host_req;
    logic [8:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic [8:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ce, we, re;
    logic [17:0] mix_out;
    logic        mix_valid, busy, overrun;

    int n_cmp = 0;
    int n_fail = 0;

    wavetable_voice_sched #(.NVOICE(4), .PHASE_W(24)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .voice_en(voice_en),
        .voice_inc(voice_inc), .host_req(host_req), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ce(ce), .we(we), .re(re),
        .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Single-port RAM seen by the DUT, preloaded with a known pattern.
    logic [15:0] mem [512];
    logic        mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 16'(i * 40503 + 7);
            mem_init <= 1'b1;
        end else begin
            if (ce && we) mem[ram_addr] <= ram_wdata;
            if (ce && re) ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: a scan accepted at the end of cycle T occupies T+1..T+1+N,
    // a host write accepted at the end of cycle H occupies H+1.
    logic [15:0] ref_mem [512];
    logic [23:0] m_phase [N];
    int          cyc = 0;
    int          scan_t = -100;
    int          host_t = -100;
    int          mix_at = -100;
    logic [17:0] m_acc = '0, m_mix_pend = '0, e_mix = '0;
    logic [8:0]  e_addr = '0, m_host_addr = '0;
    logic        m_overrun = 1'b0;
    logic        e_busy = 0, e_ce = 0, e_we = 0, e_re = 0, e_ack = 0, e_mv = 0, e_ovr = 0;

    function automatic bit in_scan(int c);
        return (c >= scan_t + 1) && (c <= scan_t + 1 + N);
    endfunction

    function automatic bit in_read(int c);
        return (c >= scan_t + 1) && (c <= scan_t + N);
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = 16'(i * 40503 + 7);
        forever begin
            int c, k, nc;
            bit bsy;
            @(posedge clk);
            c = cyc;
            if (rst) begin
                scan_t = -100; host_t = -100; mix_at = -100;
                m_acc = '0; e_mix = '0; e_addr = '0; m_overrun = 1'b0;
                for (int i = 0; i < N; i++) m_phase[i] = '0;
            end else begin
                bsy = in_scan(c) || (c == host_t + 1);
                if (sample_tick && bsy) m_overrun = 1'b1;
                if (in_read(c)) begin
                    k = c - scan_t - 1;
                    if (voice_en[k]) begin
                        m_acc = m_acc + 18'(ref_mem[m_phase[k][23:15]]);
                        m_phase[k] = m_phase[k] + voice_inc[k*24 +: 24];
                    end else begin
                        m_phase[k] = '0;
                    end
                    if (k == N - 1) begin
                        mix_at = c + 2;
                        m_mix_pend = m_acc;
                    end
                end
                if (!bsy && sample_tick) begin
                    scan_t = c;
                    m_acc = '0;
                end else if (!bsy && host_req) begin
                    host_t = c;
                    m_host_addr = host_addr;
                    ref_mem[host_addr] = host_wdata;
                end
            end
            nc = c + 1;
            e_busy = in_scan(nc);
            e_ack  = (nc == host_t + 1);
            e_we   = e_ack;
            e_re   = in_read(nc);
            e_ce   = e_re || e_we;
            if (e_re) e_addr = m_phase[nc - scan_t - 1][23:15];
            if (e_we) e_addr = m_host_addr;
            e_mv = (nc == mix_at);
            if (e_mv) e_mix = m_mix_pend;
            e_ovr = m_overrun;
            cyc = nc;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_busy", 32'(busy), 0);
                check("rst_ce", 32'(ce), 0);
                check("rst_re", 32'(re), 0);
                check("rst_we", 32'(we), 0);
                check("rst_mix_valid", 32'(mix_valid), 0);
                check("rst_overrun", 32'(overrun), 0);
            end else begin
                check("busy", 32'(busy), 32'(e_busy));
                check("ce", 32'(ce), 32'(e_ce));
                check("we", 32'(we), 32'(e_we));
                check("re", 32'(re), 32'(e_re));
                check("host_ack", 32'(host_ack), 32'(e_ack));
                check("mix_valid", 32'(mix_valid), 32'(e_mv));
                check("overrun", 32'(overrun), 32'(e_ovr));
                check("mix_out", 32'(mix_out), 32'(e_mix));
                check("ram_addr", 32'(ram_addr), 32'(e_addr));
                if (!in_scan(cyc)) check("ram_wdata", 32'(ram_wdata), 32'(host_wdata));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic host_write(input logic [8:0] a, input logic [15:0] d, output int lat);
        lat = -1;
        @(posedge clk); #1;
        host_req = 1'b1; host_addr = a; host_wdata = d;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (host_ack) begin lat = n; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1 host_req = 1'b0;
    endtask

    task automatic run_tick(output logic [17:0] mix, output int lat);
        mix = '0; lat = -1;
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        for (int n = 1; n < 30; n++) begin
            @(negedge clk);
            if (mix_valid) begin mix = mix_out; lat = n; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic tick_addr(output logic [8:0] a, output logic r);
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        @(negedge clk);
        a = ram_addr; r = re;
        repeat (8) @(posedge clk);
    endtask

    initial begin
        int lat, mv_cnt, mv_at, ack_cnt, ack_at;
        logic [17:0] mix;
        logic [8:0] a;
        logic r;
        bit ack_seen;

        rst = 1'b1; sample_tick = 1'b0; voice_en = '0; voice_inc = '0;
        host_req = 1'b0; host_addr = '0; host_wdata = '0;
        @(negedge clk);
        check("reset_mix_out", 32'(mix_out), 0);
        check("reset_ram_addr", 32'(ram_addr), 0);
        check("reset_host_ack", 32'(host_ack), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Host writes into idle scheduler.
        host_write(9'd0, 16'h1000, lat); check("hw0_latency", 32'(lat), 1);
        host_write(9'd1, 16'h2000, lat); check("hw1_latency", 32'(lat), 1);
        host_write(9'd2, 16'h3000, lat); check("hw2_latency", 32'(lat), 1);
        check("ram_word0", 32'(mem[0]), 32'h1000);
        check("ram_word1", 32'(mem[1]), 32'h2000);
        check("ram_word2", 32'(mem[2]), 32'h3000);

        // One voice stepping one RAM word per tick.
        voice_en = 4'b0001; voice_inc = 96'h008000;
        run_tick(mix, lat); check("v0_mix1", 32'(mix), 32'h01000); check("v0_lat1", 32'(lat), 6);
        repeat (14) @(posedge clk);
        run_tick(mix, lat); check("v0_mix2", 32'(mix), 32'h02000); check("v0_lat2", 32'(lat), 6);
        repeat (14) @(posedge clk);
        run_tick(mix, lat); check("v0_mix3", 32'(mix), 32'h03000); check("v0_lat3", 32'(lat), 6);
        repeat (5) @(posedge clk);

        // Full-scale sum across all voices.
        do_reset();
        host_write(9'd0, 16'hFFFF, lat);
        voice_en = 4'b1111; voice_inc = '0;
        run_tick(mix, lat); check("fullscale_mix", 32'(mix), 32'h3FFFC);
        repeat (5) @(posedge clk);

        // Half-range increment wraps the address.
        voice_en = 4'b0001; voice_inc = 96'h800000;
        tick_addr(a, r); check("wrap_addr0", 32'(a), 0);   check("wrap_re0", 32'(r), 1);
        tick_addr(a, r); check("wrap_addr1", 32'(a), 256);
        tick_addr(a, r); check("wrap_addr2", 32'(a), 0);
        tick_addr(a, r); check("wrap_addr3", 32'(a), 256);

        // Tick and host request together, then a tick during the scan.
        do_reset();
        repeat (2) @(posedge clk);
        check("pre_overrun", 32'(overrun), 0);
        mv_cnt = 0; mv_at = -1; ack_cnt = 0; ack_at = -1; ack_seen = 0;
        for (int i = 0; i <= 12; i++) begin
            @(posedge clk); #1;
            sample_tick = (i == 0 || i == 3);
            if (i == 0) begin host_req = 1'b1; host_addr = 9'h010; host_wdata = 16'hBEEF; end
            if (ack_seen) host_req = 1'b0;
            @(negedge clk);
            if (mix_valid) begin mv_cnt++; mv_at = i; end
            if (host_ack) begin ack_cnt++; ack_at = i; ack_seen = 1; end
        end
        check("coll_mix_count", 32'(mv_cnt), 1);
        check("coll_mix_cycle", 32'(mv_at), 6);
        check("coll_ack_count", 32'(ack_cnt), 1);
        check("coll_ack_cycle", 32'(ack_at), 7);
        check("coll_overrun", 32'(overrun), 1);

        // Reset in the middle of a scan.
        do_reset();
        voice_en = 4'b0001; voice_inc = 96'h800000;
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_ce", 32'(ce), 0);
        check("midrst_re", 32'(re), 0);
        check("midrst_busy", 32'(busy), 0);
        @(posedge clk); #1 rst = 1'b0;
        mv_cnt = 0;
        repeat (8) begin @(negedge clk); if (mix_valid) mv_cnt++; end
        check("midrst_no_mix", 32'(mv_cnt), 0);
        tick_addr(a, r); check("midrst_next_addr", 32'(a), 0);

        // Randomized traffic against the model.
        ack_seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 499) == 0);
            sample_tick = ($urandom_range(0, 8) == 0);
            if (host_req && ack_seen) begin
                host_req = 1'b0; ack_seen = 0;
            end else if (!host_req && $urandom_range(0, 9) == 0) begin
                host_req = 1'b1; host_addr = 9'($urandom); host_wdata = 16'($urandom);
            end
            if ($urandom_range(0, 40) == 0) begin
                voice_en = 4'($urandom);
                voice_inc = {$urandom(), $urandom(), $urandom()};
            end
            @(negedge clk);
            if (host_ack) ack_seen = 1;
        end
        @(posedge clk); #1;
        rst = 1'b0; sample_tick = 1'b0; host_req = 1'b0;
        repeat (20) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
